// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. It scans one row at a time and debounces both
// press and release, then emits a one-cycle strobe with the hex code of each accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  // Indexed by {row, col}; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_nx;
  logic [1:0]    row_idx, row_nx, col_idx, col_nx, low_idx;
  logic [DW-1:0] dwell, dwell_nx;
  logic [BW-1:0] deb, deb_nx;
  logic [3:0]    code_nx;
  logic          valid_nx, one_low, col_low;

  // Two or more low columns are ghosting or a multi-press, so they are not treated as a key.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (cols)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign col_low = ~cols[col_idx];

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    col_nx   = col_idx;
    dwell_nx = dwell;
    deb_nx   = deb;
    code_nx  = key_code;
    valid_nx = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (one_low) begin
            col_nx   = low_idx;
            deb_nx   = '0;
            state_nx = DEBOUNCE;
          end else begin
            row_nx = row_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (!col_low) begin
          state_nx = SCAN;
          row_nx   = row_idx + 2'd1;
          deb_nx   = '0;
          dwell_nx = '0;
        end else if (deb == DEB_LAST) begin
          state_nx = HELD;
          code_nx  = KEY_MAP[{row_idx, col_idx}];
          valid_nx = 1'b1;
          deb_nx   = '0;
        end else begin
          deb_nx = deb + BW'(1);
        end
      end
      HELD: begin
        if (!col_low) begin
          state_nx = RELEASE;
          deb_nx   = '0;
        end
      end
      RELEASE: begin
        if (col_low) begin
          state_nx = HELD;
          deb_nx   = '0;
        end else if (deb == DEB_LAST) begin
          state_nx = SCAN;
          row_nx   = row_idx + 2'd1;
          deb_nx   = '0;
          dwell_nx = '0;
        end else begin
          deb_nx = deb + BW'(1);
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      dwell     <= '0;
      deb       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      row_idx   <= row_nx;
      col_idx   <= col_nx;
      dwell     <= dwell_nx;
      deb       <= deb_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
    end
  end

  assign rows     = ~(4'b0001 << row_idx);
  assign key_held = (state == HELD) || (state == RELEASE);
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the rows of a 4x4 matrix keypad and reads its column lines. The column lines arrive through the two-stage input synchronizer.
- Scans rows one at a time and debounces both press and release.
- Emits a one-cycle strobe with a hex key code for each debounced press. A held key never re-triggers.
- Sits between the keypad pins and the key-history/display logic.

Parameters:
- SCAN_DIV, 16, clock cycles each row is driven before columns are sampled; must be >= 4 so a row change propagates through the 2-cycle synchronizer.
- DEBOUNCE_CYCLES, 50000, consecutive cycles a column must hold stable to accept a press or release; must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cols  input  4  synchronized column lines; active-low, pulled up externally; bit i = column i
- rows  output  4  row drives; active-low, exactly one bit low at all times; bit r = row r
- key_code  output  4  hex code of the last accepted key; holds its value between presses
- key_valid  output  1  one-cycle strobe when key_code is updated
- key_held  output  1  high while the accepted key remains pressed, including release debounce

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=SCAN, row index=0, rows=4'b1110.
  - Dwell and debounce counters = 0.
  - key_code=4'h0, key_valid=0, key_held=0.
- Key map, row r / column c (c=0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- rows is always ~(4'b0001 << row_idx). The driven row changes only in SCAN, on a row advance.
- SCAN:
  - The dwell counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, cols is sampled.
  - Exactly one bit low: latch row_idx/col_idx, clear the debounce counter, go to DEBOUNCE. The row is not advanced.
  - No bit low, or two or more bits low (ghosting/multi-press): row_idx <= row_idx+1 (3 wraps to 0), dwell counter back to 0, stay in SCAN.
- DEBOUNCE:
  - The row stays driven. Each cycle the latched column is checked.
  - Latched column high on any cycle: go to SCAN, advance the row, no output.
  - Debounce counter reaches DEBOUNCE_CYCLES-1 with the column still low: on the next edge key_code <= map(row,col), key_valid=1 for exactly one cycle, key_held=1, go to HELD.
- HELD:
  - The row stays driven; key_held=1.
  - Other columns of the driven row are ignored. Keys in other rows are invisible because those rows are not driven.
  - Latched column high: clear the debounce counter, go to RELEASE.
- RELEASE:
  - key_held stays 1.
  - Latched column low again on any cycle: return to HELD with no new key_valid.
  - Column high for DEBOUNCE_CYCLES consecutive cycles: key_held=0, go to SCAN, advance the row, dwell counter 0.
- A second key pressed while one is held never produces key_valid. It is detected only after the first key's release completes and it is found in a normal scan.
- key_valid is registered. It is never high in two consecutive cycles, and never high on the reset-release cycle.
- Reset asserted mid-press: all state returns to reset values immediately. After release, a still-held key is re-detected by a normal scan and produces one key_valid.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. Counters never wrap silently; each is cleared on every state change.
- Worst-case press latency from a stable column low on a synchronizer output is under 4*SCAN_DIV + DEBOUNCE_CYCLES + 2 cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, then no keys pressed -> rows cycles 1110, 1101, 1011, 0111, 1110 with each value held 4 cycles; key_valid never asserts; key_code=0.
- Key '6' (r1,c2) held steady -> when rows=1101, exactly one key_valid pulse with key_code=4'h6; key_held=1; rows frozen at 1101 until release plus 8 cycles.
- Key '0' bounces (column low 3 cycles, high 1, then low steady) -> no pulse on the first contact; a single pulse with key_code=4'h0 after a stable 8-cycle window.
- Key '5' held, release bounces (high 3 cycles, low 2, high steady) -> key_held stays 1 through the bounce; no second key_valid; key_held falls 8 cycles after the final rise.
- Key '1' held, then 'D' (r3,c3) pressed, then '1' released -> exactly two pulses, 4'h1 then 4'hD; the 'D' pulse comes only after the release debounce of '1'.
- Columns c0 and c1 both low on row 2 -> no key_valid, scan continues; separately, assert reset during HELD for key 'A' -> outputs go to reset values at once; after reset deasserts with 'A' still held, one pulse with key_code=4'hA.
